matdet_ge: RTL and testbench
============================

MATDET_GE -- requirements
Module: matdet_ge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: signed two's-complement fixed-point element and result width.
REQ-002 SHALL have parameter BIN_POS, default 16: fractional bits, 0 < BIN_POS < DATA_WIDTH.
REQ-003 SHALL have parameter MATRIX_SIZE, default 3: N for an NxN matrix, 2..8.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset and load strobe.
REQ-006 SHALL have port ready, output, 1: block is in LOAD and capturing matrix.
REQ-007 SHALL have port complete, output, 1: det valid, held until rst.
REQ-008 SHALL have port matrix, input, MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH: row-major; element (r,c) at bit offset (r*N+c)*DATA_WIDTH.
REQ-009 SHALL have port det, output, DATA_WIDTH: fixed-point determinant.

Function
REQ-010 SHALL compute det for any MATRIX_SIZE by Gaussian elimination using one multiplier and one sequential divider.
REQ-011 SHALL use states LOAD, SEARCH, SWAP, DIVIDE, ELIM, ACCUM, DONE.
REQ-012 LOAD: entered on every rst-high edge; capture matrix, set acc=1.0 (1<<<BIN_POS), sign=+, k=0; ready=1, complete=0.
REQ-013 LOAD->SEARCH on the first edge with rst=0; matrix changes after that edge SHALL be ignored.
REQ-014 SEARCH: scan rows r=k..N-1, one per cycle, for first a[r][k]!=0; none found -> det=0, go DONE.
REQ-015 SWAP: if r!=k, exchange rows r and k in one cycle and invert sign; r==k skips SWAP.
REQ-016 DIVIDE: for each row i>k, factor=(a[i][k]<<<BIN_POS)/a[k][k], truncated toward zero, DATA_WIDTH bits.
REQ-017 ELIM: for j=k..N-1, one element per cycle, a[i][j] -= (factor*a[k][j])>>>BIN_POS.
REQ-018 ACCUM: acc=(acc*a[k][k])>>>BIN_POS in one cycle; k++; k==N -> DONE, else SEARCH.
REQ-019 DONE: det = sign ? -acc : acc, registered; complete=1; hold until rst.
REQ-020 All products SHALL be computed at 2*DATA_WIDTH and arithmetic-shifted by BIN_POS before narrowing per REQ-030.
REQ-021 Latency from rst falling to complete SHALL be data-dependent and bounded by N*(N + N*(DATA_WIDTH+BIN_POS+2+N) + 3) cycles.
REQ-022 ready SHALL be 0 in every state except LOAD.

Reset
REQ-023 rst high at any edge, in any state, SHALL abort the computation and force LOAD next cycle.
REQ-024 Reset values: ready=1, complete=0, det=0; divider SHALL be cleared.
REQ-025 rst held high for several cycles SHALL recapture matrix every cycle; the last captured value is used.

Configuration
REQ-026 Macro MATDET_GE_SAT_EN: when defined, every narrowed product, difference and negation SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-027 Without MATDET_GE_SAT_EN, the same operations SHALL wrap by keeping the low DATA_WIDTH bits.

Structure
REQ-028 Package matdet_pkg SHALL hold the state enum, ONE constant (1<<<BIN_POS) and the saturate/wrap narrowing function.
REQ-029 Sub-module matdet_div SHALL be a sequential restoring signed divider with start/busy/done, DATA_WIDTH+BIN_POS+2 cycles per divide.
REQ-030 Narrowing SHALL go through the single package function, so REQ-026/027 apply uniformly.

Verification (DATA_WIDTH=32, BIN_POS=16, N=3)
REQ-031 Identity matrix -> complete, det=0x00010000.
REQ-032 diag(2,3,4) -> det=0x00180000.
REQ-033 rows [0,1,0],[1,0,0],[0,0,1] (SWAP path) -> det=0xFFFF0000.
REQ-034 rows [1,2,3],[2,4,6],[1,1,1] (singular, early exit) -> det=0x00000000 before the bound in REQ-021.
REQ-035 rst asserted for one cycle during ELIM, then diag(2,2,2) -> prior result never signalled; next cycle ready=1, complete=0; then det=0x00080000.
REQ-036 diag(200,200,200): with MATDET_GE_SAT_EN det=0x7FFFFFFF; without it det=0x12000000.

Source files
------------

// File: rtl/matdet_pkg.sv
// Shared types and helpers for the matdet_ge determinant engine.
// Build option: define MATDET_GE_SAT_EN to make every narrowing step saturate
// instead of wrap.
package matdet_pkg;

    // Widest element width supported by the helpers below.
    localparam int MAX_W = 64;
    localparam int WIDE  = 2 * MAX_W;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_SEARCH,
        ST_SWAP,
        ST_DIVIDE,
        ST_ELIM,
        ST_ACCUM,
        ST_DONE
    } state_e;

    // Fixed-point 1.0 for a given number of fractional bits.
    function automatic logic signed [MAX_W-1:0] fp_one(input int bin_pos);
        return MAX_W'(1) <<< bin_pos;
    endfunction

    // Reduce a wide signed intermediate to a w-bit element; the caller keeps
    // the low w bits of the returned value.
    function automatic logic signed [MAX_W-1:0] narrow(input logic signed [WIDE-1:0] x,
                                                       input int w);
`ifdef MATDET_GE_SAT_EN
        logic signed [WIDE-1:0] hi;
        logic signed [WIDE-1:0] lo;
        hi = (WIDE'(1) <<< (w - 1)) - WIDE'(1);
        lo = -(WIDE'(1) <<< (w - 1));
        if (x > hi) begin
            return hi[MAX_W-1:0];
        end else if (x < lo) begin
            return lo[MAX_W-1:0];
        end
        return x[MAX_W-1:0];
`else
        logic [WIDE-1:0] mask;
        mask = (WIDE'(1) << w) - WIDE'(1);
        return MAX_W'(x & mask);
`endif
    endfunction

endpackage

// File: rtl/matdet_div.sv
// Sequential restoring signed divider: num / den truncated toward zero.
// One setup cycle, one cycle per dividend bit, one sign-fix cycle.
module matdet_div
    import matdet_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BIN_POS    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic signed [DATA_WIDTH+BIN_POS-1:0] num_i,
    input  logic signed [DATA_WIDTH-1:0]         den_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic signed [DATA_WIDTH-1:0]         quo_o
);

    localparam int NW = DATA_WIDTH + BIN_POS;
    localparam int CW = $clog2(NW + 2);
    localparam logic [CW-1:0] LAST_STEP = CW'(NW + 1);

    logic [CW-1:0]               cnt_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        neg_q;
    logic signed [NW-1:0]        num_q;
    logic signed [DATA_WIDTH-1:0] den_q;
    logic [NW-1:0]               mag_q;
    logic [DATA_WIDTH-1:0]       dmag_q;
    logic [DATA_WIDTH:0]         rem_q;
    logic [DATA_WIDTH+1:0]       trial;
    logic signed [DATA_WIDTH-1:0] quo_q;

    // Trial subtraction of the divisor from the partial remainder.
    always_comb begin
        trial = {rem_q, mag_q[NW-1]} - {2'b00, dmag_q};
    end

    // Divider sequencing: capture, take magnitudes, shift/subtract, fix sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            neg_q  <= 1'b0;
            num_q  <= '0;
            den_q  <= '0;
            mag_q  <= '0;
            dmag_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start_i) begin
                    num_q  <= num_i;
                    den_q  <= den_i;
                    cnt_q  <= '0;
                    busy_q <= 1'b1;
                end
            end else if (cnt_q == '0) begin
                mag_q  <= num_q[NW-1] ? -num_q : num_q;
                dmag_q <= den_q[DATA_WIDTH-1] ? -den_q : den_q;
                neg_q  <= num_q[NW-1] ^ den_q[DATA_WIDTH-1];
                rem_q  <= '0;
                cnt_q  <= cnt_q + 1'b1;
            end else if (cnt_q != LAST_STEP) begin
                if (!trial[DATA_WIDTH+1]) begin
                    rem_q <= trial[DATA_WIDTH:0];
                    mag_q <= {mag_q[NW-2:0], 1'b1};
                end else begin
                    rem_q <= {rem_q[DATA_WIDTH-1:0], mag_q[NW-1]};
                    mag_q <= {mag_q[NW-2:0], 1'b0};
                end
                cnt_q <= cnt_q + 1'b1;
            end else begin
                quo_q  <= neg_q ? -mag_q[DATA_WIDTH-1:0] : mag_q[DATA_WIDTH-1:0];
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quo_o  = quo_q;

endmodule

// File: rtl/matdet_ge.sv
// Fixed-point NxN determinant by Gaussian elimination with partial pivot
// search, one shared multiplier and one sequential divider.
// Build option: MATDET_GE_SAT_EN selects saturating narrowing (see matdet_pkg).
module matdet_ge
    import matdet_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BIN_POS     = 16,
    parameter int MATRIX_SIZE = 3
) (
    input  logic                                             clk,
    input  logic                                             rst,
    output logic                                             ready,
    output logic                                             complete,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]    matrix,
    output logic signed [DATA_WIDTH-1:0]                     det
);

    localparam int IDX_W = $clog2(MATRIX_SIZE + 1);
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int DW1   = DATA_WIDTH + 1;
    localparam logic [IDX_W-1:0] N_IDX = IDX_W'(MATRIX_SIZE);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(MATRIX_SIZE - 1);
    localparam logic signed [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(fp_one(BIN_POS));

    state_e                       state_q;
    logic signed [DATA_WIDTH-1:0] a_q [MATRIX_SIZE][MATRIX_SIZE];
    logic signed [DATA_WIDTH-1:0] acc_q;
    logic signed [DATA_WIDTH-1:0] factor_q;
    logic                         sign_q;
    logic [IDX_W-1:0]             k_q, r_q, i_q, j_q;
    logic                         ready_q, complete_q;
    logic signed [DATA_WIDTH-1:0] det_q;

    logic signed [DATA_WIDTH-1:0] mul_a_n, mul_b_n;
    logic signed [PW-1:0]         mul_a, mul_b, prod, prod_sh;
    logic signed [DATA_WIDTH-1:0] prod_n, diff_n, neg_n, det_fin;
    logic signed [DW1-1:0]        diff_w, neg_w;

    logic                         div_start, div_busy, div_done;
    logic signed [DATA_WIDTH-1:0] div_quo;

    // Shared multiplier and narrowing path for elimination and accumulation.
    // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        mul_a_n = (state_q == ST_ACCUM) ? acc_q : factor_q;
        mul_b_n = (state_q == ST_ACCUM) ? a_q[k_q][k_q] : a_q[k_q][j_q];
        mul_a   = PW'(mul_a_n);
        mul_b   = PW'(mul_b_n);
        prod    = mul_a * mul_b;
        prod_sh = prod >>> BIN_POS;
        prod_n  = DATA_WIDTH'(narrow(WIDE'(prod_sh), DATA_WIDTH));
        diff_w  = DW1'(a_q[i_q][j_q]) - DW1'(prod_n);
        diff_n  = DATA_WIDTH'(narrow(WIDE'(diff_w), DATA_WIDTH));
        neg_w   = -DW1'(prod_n);
        neg_n   = DATA_WIDTH'(narrow(WIDE'(neg_w), DATA_WIDTH));
        det_fin = sign_q ? neg_n : prod_n;
    end

    assign div_start = (state_q == ST_DIVIDE) && (i_q != N_IDX) && !div_busy && !div_done;

    matdet_div #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIN_POS    (BIN_POS)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .num_i   ({a_q[i_q][k_q], {BIN_POS{1'b0}}}),
        .den_i   (a_q[k_q][k_q]),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quo_o   (div_quo)
    );

    // Elimination FSM with registered ready/complete/det.
    // NOTE: non-blocking assignments let the SWAP loop read both old rows in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            // NOTE: the matrix store is loaded from the port on reset rather than cleared.
            for (int r = 0; r < MATRIX_SIZE; r++) begin
                for (int c = 0; c < MATRIX_SIZE; c++) begin
                    a_q[r][c] <= matrix[(r*MATRIX_SIZE+c)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            acc_q      <= ONE;
            factor_q   <= '0;
            sign_q     <= 1'b0;
            k_q        <= '0;
            r_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            ready_q    <= 1'b1;
            complete_q <= 1'b0;
            det_q      <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    r_q     <= k_q;
                    ready_q <= 1'b0;
                    state_q <= ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (a_q[r_q][k_q] != '0) begin
                        i_q     <= k_q + 1'b1;
                        state_q <= (r_q != k_q) ? ST_SWAP : ST_DIVIDE;
                    end else if (r_q == LAST) begin
                        det_q      <= '0;
                        complete_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        r_q <= r_q + 1'b1;
                    end
                end
                ST_SWAP: begin
                    for (int c = 0; c < MATRIX_SIZE; c++) begin
                        a_q[k_q][c] <= a_q[r_q][c];
                        a_q[r_q][c] <= a_q[k_q][c];
                    end
                    sign_q  <= ~sign_q;
                    state_q <= ST_DIVIDE;
                end
                ST_DIVIDE: begin
                    if (i_q == N_IDX) begin
                        state_q <= ST_ACCUM;
                    end else if (div_done) begin
                        factor_q <= div_quo;
                        j_q      <= k_q;
                        state_q  <= ST_ELIM;
                    end
                end
                ST_ELIM: begin
                    a_q[i_q][j_q] <= diff_n;
                    if (j_q == LAST) begin
                        i_q     <= i_q + 1'b1;
                        state_q <= ST_DIVIDE;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                ST_ACCUM: begin
                    acc_q <= prod_n;
                    if (k_q == LAST) begin
                        det_q      <= det_fin;
                        complete_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        r_q     <= k_q + 1'b1;
                        state_q <= ST_SEARCH;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign ready    = ready_q;
    assign complete = complete_q;
    assign det      = det_q;

endmodule

// File: tb/tb_matdet_ge.sv
// Scoreboard bench for matdet_ge (DATA_WIDTH=32, BIN_POS=16, N=3).
module tb_matdet_ge;
    import matdet_pkg::*;

    localparam int DW    = 32;
    localparam int BP    = 16;
    localparam int N     = 3;
    localparam int BOUND = N * (N + N * (DW + BP + 2 + N) + 3);

    typedef struct {
        string         name;
        logic [DW-1:0] det;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ready;
    logic              complete;
    logic [N*N*DW-1:0] matrix = '0;
    logic [DW-1:0]     det;
    logic [N*N*DW-1:0] garbage;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    matdet_ge #(
        .DATA_WIDTH  (DW),
        .BIN_POS     (BP),
        .MATRIX_SIZE (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .complete (complete),
        .matrix   (matrix),
        .det      (det)
    );

    always #5 clk = ~clk;

    // Integer-valued 3x3 matrix, row-major, as 16.16 fixed point.
    function automatic logic [N*N*DW-1:0] mat3(input int v0, input int v1, input int v2,
                                               input int v3, input int v4, input int v5,
                                               input int v6, input int v7, input int v8);
        int v[9];
        logic [N*N*DW-1:0] m;
        v[0] = v0; v[1] = v1; v[2] = v2;
        v[3] = v3; v[4] = v4; v[5] = v5;
        v[6] = v6; v[7] = v7; v[8] = v8;
        m = '0;
        for (int i = 0; i < 9; i++) m[i*DW +: DW] = DW'(v[i] * 65536);
        return m;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every rising complete must match the oldest pending result.
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (complete === 1'b1 && prev !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_complete: det 0x%08h with no result pending", det);
                end else begin
                    e = sb_q.pop_front();
                    check(e.name, det, e.det);
                end
            end
            prev = complete;
        end
    end

    // Hold rst two cycles: first with a decoy matrix, then the real one.
    task automatic load_matrix(input logic [N*N*DW-1:0] m);
        @(negedge clk);
        rst    = 1'b1;
        matrix = garbage;
        @(negedge clk);
        matrix = m;
        @(negedge clk);
        check("rst_ready", DW'(ready), 1);
        check("rst_complete", DW'(complete), 0);
        check("rst_det", det, 0);
    endtask

    // Release rst, scramble the input port, and wait (bounded) for the result.
    task automatic release_and_wait(input string name, input logic [DW-1:0] exp);
        exp_t e;
        e.name = name;
        e.det  = exp;
        sb_q.push_back(e);
        rst = 1'b0;
        @(negedge clk);
        matrix = garbage;
        check({name, "_busy_ready"}, DW'(ready), 0);
        for (int c = 1; c < BOUND && complete !== 1'b1; c++) @(negedge clk);
        check({name, "_latency"}, DW'(complete), 1);
        if (complete !== 1'b1) begin
            if (sb_q.size() != 0) void'(sb_q.pop_back());
        end else begin
            repeat (4) @(negedge clk);
            check({name, "_hold_complete"}, DW'(complete), 1);
            check({name, "_hold_det"}, det, exp);
        end
    endtask

    task automatic run(input string name, input logic [N*N*DW-1:0] m, input logic [DW-1:0] exp);
        load_matrix(m);
        release_and_wait(name, exp);
    endtask

    initial begin : stimulus
        logic [DW-1:0] sat_exp;
        garbage = mat3(7, 0, 0, 0, 7, 0, 0, 0, 7);
        repeat (2) @(negedge clk);

        run("identity",     mat3(1, 0, 0, 0, 1, 0, 0, 0, 1),    32'h0001_0000);
        run("diag_2_3_4",   mat3(2, 0, 0, 0, 3, 0, 0, 0, 4),    32'h0018_0000);
        run("swap_r1",      mat3(0, 1, 0, 1, 0, 0, 0, 0, 1),    32'hFFFF_0000);
        run("swap_r2",      mat3(0, 0, 1, 0, 1, 0, 1, 0, 0),    32'hFFFF_0000);
        run("singular",     mat3(1, 2, 3, 2, 4, 6, 1, 1, 1),    32'h0000_0000);
        run("zero_col0",    mat3(0, 1, 2, 0, 3, 4, 0, 5, 6),    32'h0000_0000);
        run("half_factor",  mat3(2, 1, 0, 1, 3, 0, 0, 0, 1),    32'h0005_0000);
        run("neg_pivot",    mat3(-2, 1, 0, 1, 3, 0, 0, 0, 1),   32'hFFF9_0000);
        run("trunc_pos",    mat3(3, 1, 0, 1, 1, 0, 0, 0, 1),    32'h0002_0001);
        run("trunc_neg",    mat3(-3, 1, 0, 1, 1, 0, 0, 0, 1),   32'hFFFC_0001);

        // Abort mid-elimination with a one-cycle rst that also loads diag(2,2,2).
        load_matrix(mat3(3, 1, 0, 1, 1, 0, 0, 0, 1));
        rst = 1'b0;
        @(negedge clk);
        for (int c = 0; c < BOUND && dut.state_q != ST_ELIM; c++) @(negedge clk);
        check("abort_reached_elim", DW'(dut.state_q == ST_ELIM), 1);
        rst    = 1'b1;
        matrix = mat3(2, 0, 0, 0, 2, 0, 0, 0, 2);
        @(negedge clk);
        check("abort_ready", DW'(ready), 1);
        check("abort_complete", DW'(complete), 0);
        release_and_wait("abort_then_diag2", 32'h0008_0000);

`ifdef MATDET_GE_SAT_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = 32'h1200_0000;
`endif
        run("diag_200", mat3(200, 0, 0, 0, 200, 0, 0, 0, 200), sat_exp);

        @(negedge clk);
        check("scoreboard_drained", DW'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
